// File: rtl/fifo_pkg.sv
// Shared constants for the single-clock FIFO.
//   DATA_WIDTH_DEF : default width of one stored word
//   DEPTH_DEF      : default number of entries (power of two, >= 2)
//   ADDR_W         : storage index width derived from DEPTH_DEF
package fifo_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned DEPTH_DEF      = 16;
    localparam int unsigned ADDR_W         = $clog2(DEPTH_DEF);

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// Simple dual-port register array: one write port, one synchronous read port.
// The storage array itself is not reset; only the read-data register is.
//   clk   : clock
//   rst   : asynchronous active-low reset (clears the read register only)
//   we    : write enable, waddr/wdata captured on the rising edge
//   waddr : write address
//   wdata : write data
//   re    : read enable, rdata <= mem[raddr] on the rising edge
//   raddr : read address
//   rdata : registered read data, holds when re is low
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned DEPTH      = DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic [$clog2(DEPTH)-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic                         re,
    input  logic [$clog2(DEPTH)-1:0]     raddr,
    output logic [DATA_WIDTH-1:0]        rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage write port; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port, holds its last value when no read is issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule : fifo_mem

// File: rtl/fifo.sv
// Synchronous single-clock FIFO with registered read data and full/empty flags.
// Writes when full and reads when empty are silently dropped.
//   clk   : sole clock, all state changes on the rising edge
//   rst   : asynchronous active-low reset
//   w_en  : write request, wdata captured when accepted (w_en && !full)
//   wdata : write data
//   r_en  : read request, accepted when r_en && !empty
//   rdata : registered read data, valid the cycle after an accepted read
//   full  : DEPTH words stored (decoded from pointer registers only)
//   empty : zero words stored (decoded from pointer registers only)
module fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned DEPTH      = DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             wr_acc_c;
    logic             rd_acc_c;

    // Flags: the extra MSB distinguishes a full buffer from an empty one
    // when the index bits coincide.
    always_comb begin
        empty = (wptr == rptr);
        full  = (wptr[IDX_W-1:0] == rptr[IDX_W-1:0]) && (wptr[IDX_W] != rptr[IDX_W]);
    end

    // Each side is qualified independently against this cycle's flags.
    always_comb begin
        wr_acc_c = w_en && !full;
        rd_acc_c = r_en && !empty;
    end

    // Write pointer, wraps modulo 2*DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
        end else if (wr_acc_c) begin
            wptr <= wptr + PTR_W'(1);
        end
    end

    // Read pointer, wraps modulo 2*DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rptr <= '0;
        end else if (rd_acc_c) begin
            rptr <= rptr + PTR_W'(1);
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc_c),
        .waddr (wptr[IDX_W-1:0]),
        .wdata (wdata),
        .re    (rd_acc_c),
        .raddr (rptr[IDX_W-1:0]),
        .rdata (rdata)
    );

endmodule : fifo

// File: tb/tb_fifo.sv
// Scoreboard bench for fifo: stimulus updates a queue-based reference model
// and pushes the expected post-edge outputs; a monitor pops and compares.
module tb_fifo;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          w_en;
    logic          r_en;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          full;
    logic          empty;

    always #5 clk = ~clk;

    fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .w_en  (w_en),
        .wdata (wdata),
        .r_en  (r_en),
        .rdata (rdata),
        .full  (full),
        .empty (empty)
    );

    typedef struct {
        logic [DW-1:0] rdata;
        logic          empty;
        logic          full;
        string         tag;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] model_rd = '0;
    string         phase = "init";
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock of stimulus; the model decides acceptance from its own occupancy.
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
        exp_t e;
        bit   wr_ok;
        bit   rd_ok;
        @(negedge clk);
        rst   = 1'b1;
        w_en  = w;
        r_en  = r;
        wdata = d;
        wr_ok = w && (model_q.size() < DEPTH);
        rd_ok = r && (model_q.size() != 0);
        if (rd_ok) model_rd = model_q.pop_front();
        if (wr_ok) model_q.push_back(d);
        e.rdata = model_rd;
        e.empty = (model_q.size() == 0);
        e.full  = (model_q.size() == DEPTH);
        e.tag   = phase;
        exp_q.push_back(e);
    endtask

    // Reset held two cycles with random inputs; left asserted, released by next step.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_empty_async", 32'(empty), 32'd1);
        check("reset_full_async", 32'(full), 32'd0);
        check("reset_rdata_async", 32'(rdata), 32'd0);
        repeat (2) begin
            @(negedge clk);
            w_en  = 1'($urandom_range(0, 1));
            r_en  = 1'($urandom_range(0, 1));
            wdata = DW'($urandom);
        end
        #1;
        check("reset_empty_hold", 32'(empty), 32'd1);
        check("reset_full_hold", 32'(full), 32'd0);
        check("reset_rdata_hold", 32'(rdata), 32'd0);
        w_en = 1'b0;
        r_en = 1'b0;
        model_q.delete();
        model_rd = '0;
    endtask

    // Monitor: the DUT presents rdata/flags every cycle after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.tag, ".rdata"}, 32'(rdata), 32'(e.rdata));
                check({e.tag, ".empty"}, 32'(empty), 32'(e.empty));
                check({e.tag, ".full"}, 32'(full), 32'(e.full));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b0;
        w_en  = 1'b0;
        r_en  = 1'b0;
        wdata = '0;
        do_reset();

        // Ordered pass-through; first write lands on the first edge after release.
        phase = "pass";
        step(1'b1, 1'b0, 8'h11);
        step(1'b1, 1'b0, 8'h22);
        step(1'b1, 1'b0, 8'h33);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        // Underflow: rdata holds, then a fresh write/read round trip.
        phase = "underflow";
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 8'h77);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        // Fill, overflow attempt, drain.
        phase = "fill";
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, DW'(i));
        phase = "overflow";
        step(1'b1, 1'b0, 8'hAA);
        phase = "drain";
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h00);

        // Simultaneous read/write at occupancy 4.
        phase = "simul4";
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, DW'($urandom));
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, DW'($urandom));
        // Top up to full, then both: read proceeds, write dropped.
        phase = "simul_full";
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, DW'($urandom));
        step(1'b1, 1'b1, 8'hEE);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00);
        // Both on empty: only the write proceeds, its word not yet readable.
        phase = "simul_empty";
        step(1'b1, 1'b1, 8'h5C);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        // Mid-stream asynchronous reset after 5 writes.
        phase = "midreset";
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(8'h40 + i));
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("midreset_empty_async", 32'(empty), 32'd1);
        check("midreset_full_async", 32'(full), 32'd0);
        check("midreset_rdata_async", 32'(rdata), 32'd0);
        model_q.delete();
        model_rd = '0;
        w_en = 1'b0;
        r_en = 1'b0;
        @(negedge clk);
        phase = "post_midreset";
        step(1'b1, 1'b0, 8'h5A);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        // Random interleaving with alternating bias to cross full/empty and wrap pointers.
        phase = "random";
        for (int blk = 0; blk < 8; blk++) begin
            int unsigned wp;
            int unsigned rp;
            wp = (blk % 2 == 0) ? 80 : 25;
            rp = (blk % 2 == 0) ? 25 : 80;
            for (int i = 0; i < 40; i++) begin
                step(1'($urandom_range(0, 99) < wp), 1'($urandom_range(0, 99) < rp), DW'($urandom));
            end
        end
        step(1'b0, 1'b0, 8'h00);

        @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fifo
